// File: rtl/keypad_event_decoder.sv
// keypad_event_decoder: windowed debounce of scanner key codes into a one-event-per-press FIFO with valid/ready output
module keypad_event_decoder #(
    parameter int SCAN_PERIOD = 4,
    parameter int DEBOUNCE_WIN = 3,
    parameter int RELEASE_WIN = 2,
    parameter int FIFO_DEPTH = 4,
    parameter logic [3:0] NONE_CODE = 4'd9
) (
    input  logic       clk_100Hz,
    input  logic       reset,
    input  logic [3:0] keyValue,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [3:0] evt_key,
    output logic       key_held,
    output logic [3:0] held_key,
    output logic       overflow
);
    localparam int WW = $clog2(SCAN_PERIOD);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(DEBOUNCE_WIN + 1);
    localparam int RW = $clog2(RELEASE_WIN + 1);
    typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;
    state_t state;
    logic [WW-1:0] wcnt;
    logic [3:0] win_code, cur_code, cand;
    logic conflict, cur_conf, in_valid, win_end, win_valid, push, do_push, pop, full;
    logic [SW-1:0] stable;
    logic [RW-1:0] rel;
    logic [3:0] mem [FIFO_DEPTH];
    logic [FW-1:0] wp, rp;
    logic [FW:0] count;
    // The current sample is folded in so the window-end cycle counts toward its own window
    always_comb begin
        in_valid = keyValue <= 4'd8;
        cur_code = win_code != NONE_CODE ? win_code : in_valid ? keyValue : NONE_CODE;
        cur_conf = conflict || (win_code != NONE_CODE && in_valid && keyValue != win_code);
        win_end = wcnt == WW'(SCAN_PERIOD - 1);
        win_valid = win_end && !cur_conf && cur_code != NONE_CODE;
        push = win_valid && state == CAND && cur_code == cand && stable == SW'(DEBOUNCE_WIN - 1);
        evt_valid = count != '0;
        pop = evt_valid && evt_ready;
        full = count == (FW+1)'(FIFO_DEPTH);
        do_push = push && (!full || pop);
        evt_key = evt_valid ? mem[rp] : NONE_CODE;
        key_held = state == PRESSED;
        held_key = key_held ? cand : NONE_CODE;
    end
    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            wcnt <= '0;
            win_code <= NONE_CODE;
            conflict <= 1'b0;
        end else begin
            wcnt <= wcnt + 1'b1;
            win_code <= win_end ? NONE_CODE : cur_code;
            conflict <= win_end ? 1'b0 : cur_conf;
        end
    end
    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cand <= NONE_CODE;
            stable <= '0;
            rel <= '0;
        end else if (win_end) begin
            case (state)
                IDLE: if (win_valid) begin
                    state <= CAND;
                    cand <= cur_code;
                    stable <= SW'(1);
                end
                CAND: if (!win_valid) begin
                    state <= IDLE;
                end else if (cur_code != cand) begin
                    cand <= cur_code;
                    stable <= SW'(1);
                end else begin
                    stable <= stable == SW'(DEBOUNCE_WIN) ? stable : stable + 1'b1;
                    if (push) state <= PRESSED;
                end
                PRESSED: if (win_valid) begin
                    rel <= '0;
                end else if (rel == RW'(RELEASE_WIN - 1)) begin
                    state <= IDLE;
                    rel <= '0;
                end else begin
                    rel <= rel + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            wp <= wp + FW'(do_push);
            rp <= rp + FW'(pop);
            count <= count + (FW+1)'(do_push) - (FW+1)'(pop);
            overflow <= push && full && !pop;
        end
    end
    always_ff @(posedge clk_100Hz) begin
        if (do_push) mem[wp] <= cand;
    end
endmodule

// File: tb/tb_keypad_event_decoder.sv
// tb_keypad_event_decoder: directed presses, bounces, conflicts, overflow and reset checks
module tb_keypad_event_decoder;
    logic clk_100Hz = 1'b0;
    logic reset = 1'b0;
    logic [3:0] keyValue = 4'd9;
    logic evt_ready = 1'b1;
    logic evt_valid, key_held, overflow;
    logic [3:0] evt_key, held_key;
    int n_chk = 0, n_pass = 0, pops = 0, ovs = 0;
    logic [3:0] popq [$];

    keypad_event_decoder dut (
        .clk_100Hz(clk_100Hz), .reset(reset), .keyValue(keyValue),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .key_held(key_held), .held_key(held_key), .overflow(overflow)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    always @(posedge clk_100Hz) begin
        if (reset && evt_valid && evt_ready) begin
            pops++;
            popq.push_back(evt_key);
        end
        if (reset && overflow) ovs++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic [3:0] v);
        keyValue = v;
        @(negedge clk_100Hz);
    endtask

    task automatic win(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(4'd9); cyc(4'd9); cyc(c); cyc(4'd9);
        end
    endtask

    task automatic press(input logic [3:0] c);
        win(c, 3);
        win(4'd9, 2);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " valid"}, evt_valid, 0);
        chk({tag, " key"}, evt_key, 9);
        chk({tag, " held"}, key_held, 0);
        chk({tag, " held_key"}, held_key, 9);
        chk({tag, " ovf"}, overflow, 0);
    endtask

    initial begin
        int p0;
        repeat (2) @(negedge clk_100Hz);
        chk_reset_outs("rst");
        reset = 1'b1;
        // single press of 5
        win(4'd5, 2);
        chk("t1 early valid", evt_valid, 0);
        win(4'd5, 1);
        chk("t1 valid", evt_valid, 1);
        chk("t1 key", evt_key, 5);
        chk("t1 held", key_held, 1);
        chk("t1 held_key", held_key, 5);
        win(4'd9, 1);
        chk("t1 held after 1 empty", key_held, 1);
        chk("t1 popped", evt_valid, 0);
        win(4'd9, 1);
        chk("t1 released", key_held, 0);
        chk("t1 held_key rel", held_key, 9);
        chk("t1 pops", pops, 1);
        chk("t1 pop key", popq[0], 5);
        // bounce
        p0 = pops;
        win(4'd5, 2); win(4'd9, 1); win(4'd5, 2); win(4'd9, 1);
        chk("t2 no event", pops - p0, 0);
        chk("t2 held", key_held, 0);
        // long hold of 7 with one gap
        p0 = pops;
        win(4'd7, 5); win(4'd9, 1); win(4'd7, 5);
        chk("t3 held mid", key_held, 1);
        win(4'd9, 1);
        chk("t3 held 1 empty", key_held, 1);
        win(4'd9, 1);
        chk("t3 released", key_held, 0);
        chk("t3 one event", pops - p0, 1);
        chk("t3 key", popq[popq.size() - 1], 7);
        // conflicting codes in one window
        p0 = pops;
        for (int i = 0; i < 5; i++) begin
            cyc(4'd3); cyc(4'd9); cyc(4'd6); cyc(4'd9);
        end
        chk("t4 no event", pops - p0, 0);
        chk("t4 held", key_held, 0);
        chk("t4 valid", evt_valid, 0);
        // overflow with stalled consumer
        evt_ready = 1'b0;
        p0 = pops;
        for (int k = 0; k < 5; k++) press(4'(k));
        chk("t5 ovf pulses", ovs, 1);
        chk("t5 valid", evt_valid, 1);
        chk("t5 head", evt_key, 0);
        evt_ready = 1'b1;
        win(4'd9, 2);
        chk("t5 pops", pops - p0, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t5 order %0d", k), popq[p0 + k], k);
        chk("t5 drained", evt_valid, 0);
        chk("t5 ovf idle", overflow, 0);
        // reset mid-press with two queued
        evt_ready = 1'b0;
        press(4'd1);
        win(4'd2, 3);
        chk("t6 held pre", key_held, 1);
        chk("t6 valid pre", evt_valid, 1);
        #2 reset = 1'b0;
        #1 chk_reset_outs("t6 rst");
        @(negedge clk_100Hz);
        reset = 1'b1;
        win(4'd2, 2);
        chk("t6 no early", evt_valid, 0);
        win(4'd2, 1);
        chk("t6 fresh valid", evt_valid, 1);
        chk("t6 fresh key", evt_key, 2);
        chk("t6 fresh held", held_key, 2);
        p0 = pops;
        evt_ready = 1'b1;
        win(4'd9, 2);
        chk("t6 single", pops - p0, 1);
        chk("t6 empty", evt_valid, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
